// File: rtl/bus_port_pkg.sv
// Shared defaults and sizing helpers for the bus port FIFO pair.
package bus_port_pkg;

  localparam int unsigned DEF_PCKG_SZ = 16;
  localparam int unsigned DEF_DEPTH   = 8;

  // Occupancy must be able to represent 0..depth inclusive.
  function automatic int unsigned count_w(input int unsigned d);
    return $clog2(d + 1);
  endfunction

endpackage

// File: rtl/port_fifo.sv
// Single circular first-word-fall-through FIFO with occupancy, full and
// sticky overflow status.
module port_fifo
  import bus_port_pkg::*;
#(
  parameter int unsigned pckg_sz = DEF_PCKG_SZ,
  parameter int unsigned depth   = DEF_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_wr,
  input  logic [pckg_sz-1:0]          i_wdata,
  input  logic                        i_rd,
  output logic [pckg_sz-1:0]          o_rdata,
  output logic                        o_pndng,
  output logic                        o_full,
  output logic                        o_ovf,
  output logic [count_w(depth)-1:0]   o_count
);

  localparam int unsigned AW = $clog2(depth);
  localparam int unsigned CW = count_w(depth);
  localparam logic [CW-1:0] FULL_CNT = CW'(depth);

  logic [pckg_sz-1:0] r_mem [depth];
  logic [AW-1:0]      r_wptr;
  logic [AW-1:0]      r_rptr;
  logic [CW-1:0]      r_count;
  logic               r_ovf;

  logic w_empty;
  logic w_full;
  logic w_do_rd;
  logic w_do_wr;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);
  // A pop on empty is ignored; a write when full only lands if a pop frees a slot.
  assign w_do_rd = i_rd && !w_empty;
  assign w_do_wr = i_wr && (!w_full || w_do_rd);

  // NOTE: storage carries no reset; pointers and count define validity, so
  // clearing the array would only cost flops and reset fanout.
  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_do_wr) r_wptr <= r_wptr + 1'b1;
      if (w_do_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (i_wr && !w_do_wr) r_ovf <= 1'b1;
    end
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_pndng = !w_empty;
  assign o_full  = w_full;
  assign o_ovf   = r_ovf;
  assign o_count = r_count;

endmodule

// File: rtl/bus_port_fifo.sv
// Device/bus port: independent TX (device->bus) and RX (bus->device) FIFOs.
module bus_port_fifo
  import bus_port_pkg::*;
#(
  parameter int unsigned pckg_sz = DEF_PCKG_SZ,
  parameter int unsigned depth   = DEF_DEPTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      dev_push,
  input  logic [pckg_sz-1:0]        dev_dpush,
  input  logic                      pop,
  output logic [pckg_sz-1:0]        D_pop,
  output logic                      pndng,
  input  logic                      push,
  input  logic [pckg_sz-1:0]        D_push,
  input  logic                      dev_pop,
  output logic [pckg_sz-1:0]        dev_dpop,
  output logic                      dev_pndng,
  output logic                      tx_full,
  output logic                      rx_full,
  output logic                      tx_ovf,
  output logic                      rx_ovf,
  output logic [count_w(depth)-1:0] tx_count,
  output logic [count_w(depth)-1:0] rx_count
);

  port_fifo #(.pckg_sz(pckg_sz), .depth(depth)) u_tx (
    .clk     (clk),
    .reset   (reset),
    .i_wr    (dev_push),
    .i_wdata (dev_dpush),
    .i_rd    (pop),
    .o_rdata (D_pop),
    .o_pndng (pndng),
    .o_full  (tx_full),
    .o_ovf   (tx_ovf),
    .o_count (tx_count)
  );

  port_fifo #(.pckg_sz(pckg_sz), .depth(depth)) u_rx (
    .clk     (clk),
    .reset   (reset),
    .i_wr    (push),
    .i_wdata (D_push),
    .i_rd    (dev_pop),
    .o_rdata (dev_dpop),
    .o_pndng (dev_pndng),
    .o_full  (rx_full),
    .o_ovf   (rx_ovf),
    .o_count (rx_count)
  );

endmodule

// File: tb/tb_bus_port_fifo.sv
// Randomized and directed bench for bus_port_fifo against a queue-based model.
module tb_bus_port_fifo;

  localparam int DEPTH = 8;
  localparam int W     = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          dev_push, pop, push, dev_pop;
  logic [W-1:0]  dev_dpush, D_push;
  logic [W-1:0]  D_pop, dev_dpop;
  logic          pndng, dev_pndng, tx_full, rx_full, tx_ovf, rx_ovf;
  logic [CW-1:0] tx_count, rx_count;

  bus_port_fifo #(.pckg_sz(W), .depth(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .dev_push  (dev_push),
    .dev_dpush (dev_dpush),
    .pop       (pop),
    .D_pop     (D_pop),
    .pndng     (pndng),
    .push      (push),
    .D_push    (D_push),
    .dev_pop   (dev_pop),
    .dev_dpop  (dev_dpop),
    .dev_pndng (dev_pndng),
    .tx_full   (tx_full),
    .rx_full   (rx_full),
    .tx_ovf    (tx_ovf),
    .rx_ovf    (rx_ovf),
    .tx_count  (tx_count),
    .rx_count  (rx_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] tx_q[$];
  logic [W-1:0] rx_q[$];
  bit           tx_ovf_m, rx_ovf_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One queue's behaviour per edge, written from the queue rules directly.
  task automatic model_q(inout logic [W-1:0] q[$], inout bit ovf,
                         input bit wr, input logic [W-1:0] d, input bit rd);
    bit was_full = (q.size() == DEPTH);
    if (rd && q.size() != 0) void'(q.pop_front());
    if (wr) begin
      if (was_full && !rd) ovf = 1'b1;
      else q.push_back(d);
    end
  endtask

  task automatic check_all(input string ctx);
    check({ctx, ".tx_count"}, 32'(tx_count), 32'(tx_q.size()));
    check({ctx, ".pndng"},    32'(pndng),    32'(tx_q.size() != 0));
    check({ctx, ".tx_full"},  32'(tx_full),  32'(tx_q.size() == DEPTH));
    check({ctx, ".tx_ovf"},   32'(tx_ovf),   32'(tx_ovf_m));
    if (tx_q.size() != 0) check({ctx, ".D_pop"}, 32'(D_pop), 32'(tx_q[0]));
    check({ctx, ".rx_count"}, 32'(rx_count), 32'(rx_q.size()));
    check({ctx, ".dev_pndng"},32'(dev_pndng),32'(rx_q.size() != 0));
    check({ctx, ".rx_full"},  32'(rx_full),  32'(rx_q.size() == DEPTH));
    check({ctx, ".rx_ovf"},   32'(rx_ovf),   32'(rx_ovf_m));
    if (rx_q.size() != 0) check({ctx, ".dev_dpop"}, 32'(dev_dpop), 32'(rx_q[0]));
  endtask

  task automatic step(input string ctx,
                      input bit tpu, input logic [W-1:0] td, input bit tpo,
                      input bit rpu, input logic [W-1:0] rdat, input bit rpo);
    dev_push = tpu; dev_dpush = td; pop = tpo;
    push = rpu; D_push = rdat; dev_pop = rpo;
    @(posedge clk);
    model_q(tx_q, tx_ovf_m, tpu, td, tpo);
    model_q(rx_q, rx_ovf_m, rpu, rdat, rpo);
    #1;
    check_all(ctx);
  endtask

  task automatic idle_inputs();
    dev_push = 0; pop = 0; push = 0; dev_pop = 0;
    dev_dpush = '0; D_push = '0;
  endtask

  task automatic clear_model();
    tx_q.delete(); rx_q.delete();
    tx_ovf_m = 0; rx_ovf_m = 0;
  endtask

  initial begin
    logic [W-1:0] v;
    reset = 1'b0;
    idle_inputs();
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b1;

    // Three writes then three pops; order and pndng drop.
    for (int i = 0; i < 3; i++) step("fwft_wr", 1, W'(16'h00A1 + i), 0, 0, '0, 0);
    for (int i = 0; i < 3; i++) begin
      check("fwft_head", 32'(D_pop), 32'(16'h00A1 + i));
      step("fwft_rd", 0, '0, 1, 0, '0, 0);
    end
    check("fwft_pndng_low", 32'(pndng), 32'(0));

    // Nine writes into depth 8: full, overflow, ninth packet dropped.
    for (int i = 0; i < 9; i++) step("ovf_wr", 1, W'(16'h0B00 + i), 0, 0, '0, 0);
    check("ovf_count", 32'(tx_count), 32'(DEPTH));
    check("ovf_flag", 32'(tx_ovf), 32'(1));
    for (int i = 0; i < 8; i++) step("ovf_drain", 0, '0, 1, 0, '0, 0);
    check("ovf_drained_pndng", 32'(pndng), 32'(0));

    // Reset to clear sticky overflow before the full write+pop case.
    #2 reset = 1'b0; #1 reset = 1'b1;
    clear_model();
    @(posedge clk); #1;
    check_all("rst_mid");

    for (int i = 0; i < 8; i++) step("fullwp_fill", 1, W'(16'h0C00 + i), 0, 0, '0, 0);
    step("fullwp_both", 1, 16'h1234, 1, 0, '0, 0);
    check("fullwp_count", 32'(tx_count), 32'(DEPTH));
    check("fullwp_noovf", 32'(tx_ovf), 32'(0));
    for (int i = 0; i < 7; i++) step("fullwp_pop", 0, '0, 1, 0, '0, 0);
    check("fullwp_8th", 32'(D_pop), 32'(16'h1234));
    step("fullwp_pop", 0, '0, 1, 0, '0, 0);

    // Empty RX with simultaneous push and pop: no bypass.
    step("rx_emptywp", 0, '0, 0, 1, 16'hBEEF, 1);
    check("rx_emptywp_count", 32'(rx_count), 32'(1));
    check("rx_emptywp_data", 32'(dev_dpop), 32'(16'hBEEF));
    step("rx_emptywp_pop", 0, '0, 0, 0, '0, 1);

    // 20 push/pop pairs through RX: wraps the pointers twice.
    for (int i = 0; i < 20; i++) begin
      step("rx_wr", 0, '0, 0, 1, W'(16'hD000 + i), 0);
      step("rx_rd", 0, '0, 0, 0, '0, 1);
    end
    check("rx_wrap_count", 32'(rx_count), 32'(0));

    // Async reset mid-cycle with tx_count=5 and tx_ovf=1.
    for (int i = 0; i < 9; i++) step("ar_fill", 1, W'(16'hE000 + i), 0, 0, '0, 0);
    for (int i = 0; i < 3; i++) step("ar_pop", 0, '0, 1, 0, '0, 0);
    check("ar_pre_count", 32'(tx_count), 32'(5));
    idle_inputs();
    #2 reset = 1'b0;
    #1;
    clear_model();
    check("ar_pndng", 32'(pndng), 32'(0));
    check("ar_count", 32'(tx_count), 32'(0));
    check("ar_ovf", 32'(tx_ovf), 32'(0));
    // Writes/pops while reset is low are ignored.
    dev_push = 1; dev_dpush = 16'hFFFF; push = 1; D_push = 16'hFFFF;
    @(posedge clk); #1;
    check_all("rst_low_edge");
    idle_inputs();
    #2 reset = 1'b1;

    // Random traffic on both directions.
    for (int i = 0; i < 400; i++) begin
      bit heavy = (i % 100) < 50;
      v = W'($urandom);
      step("rand",
           heavy ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0), v,
           heavy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
           $urandom_range(0, 1) == 1, W'($urandom),
           $urandom_range(0, 1) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bus_port_fifo.md
BUS_PORT_FIFO -- requirements
Module: bus_port_fifo

Interface
REQ-001 SHALL have parameter pckg_sz, default 16, meaning packet width in bits.
REQ-002 SHALL have parameter depth, default 8, meaning entries per direction; power of two, >= 2.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port dev_push  input  1  device writes dev_dpush into TX queue.
REQ-006 SHALL have port dev_dpush  input  pckg_sz  device packet toward the bus.
REQ-007 SHALL have port pop  input  1  bus driver consumes TX head.
REQ-008 SHALL have port D_pop  output  pckg_sz  TX head packet presented to the bus driver.
REQ-009 SHALL have port pndng  output  1  TX queue non-empty.
REQ-010 SHALL have port push  input  1  bus driver delivers D_push into RX queue.
REQ-011 SHALL have port D_push  input  pckg_sz  packet from the bus driver.
REQ-012 SHALL have port dev_pop  input  1  device consumes RX head.
REQ-013 SHALL have port dev_dpop  output  pckg_sz  RX head packet to the device.
REQ-014 SHALL have port dev_pndng  output  1  RX queue non-empty.
REQ-015 SHALL have ports tx_full, rx_full  output  1 each  queue holds depth entries.
REQ-016 SHALL have ports tx_ovf, rx_ovf  output  1 each  sticky overflow flags.
REQ-017 SHALL have ports tx_count, rx_count  output  $clog2(depth+1) each  occupancy.

Function
REQ-018 SHALL implement TX and RX as independent circular FIFOs with read/write pointers wrapping from depth-1 to 0.
REQ-019 SHALL present the head entry combinationally on D_pop/dev_dpop (first-word fall-through); value when empty is the last-read slot, don't-care.
REQ-020 SHALL assert pndng/dev_pndng exactly when count != 0, registered-count derived, no extra latency: a write at edge N is visible at the output after edge N.
REQ-021 SHALL ignore a pop on an empty queue: no pointer or count change, no error flag.
REQ-022 SHALL drop a write to a full queue without pop: no pointer/count change, overflow flag set at that edge.
REQ-023 SHALL, on simultaneous write+pop when full, perform both: count stays depth, no overflow.
REQ-024 SHALL, on simultaneous write+pop when empty, accept the write, ignore the pop; count becomes 1 (no bypass).
REQ-025 SHALL, on simultaneous write+pop otherwise, perform both with count unchanged.
REQ-026 SHALL keep overflow flags set until reset; no other clear path.
REQ-027 SHALL keep TX and RX fully independent: activity on one never alters the other.

Reset
REQ-028 SHALL, while reset is low, force all pointers and counts to 0, pndng/dev_pndng/tx_full/rx_full/tx_ovf/rx_ovf to 0, asynchronously.
REQ-029 SHALL discard queue contents on reset asserted mid-operation; storage array need not be cleared.
REQ-030 SHALL ignore all writes/pops on the first rising edge at which reset is low.

Structure
REQ-031 SHALL place default pckg_sz, default depth and the count-width calculation in shared package bus_port_pkg.
REQ-032 SHALL implement one sub-module port_fifo (single FIFO with full/empty/count/ovf), instantiated once for TX and once for RX.

Verification
REQ-033 SHALL cover: dev_push 0x00A1..0x00A3 on three edges, then pop three times -> D_pop shows 0x00A1,0x00A2,0x00A3 in order; pndng drops after third pop.
REQ-034 SHALL cover: 9 consecutive dev_push, depth 8 -> tx_count=8, tx_full=1, tx_ovf=1 after ninth edge, 9th packet never appears on D_pop.
REQ-035 SHALL cover: full TX, one edge with dev_push 0x1234 and pop -> tx_count stays 8, tx_ovf=0, 0x1234 emerges as 8th subsequent pop.
REQ-036 SHALL cover: empty RX, push=1 D_push=0xBEEF with dev_pop=1 -> rx_count=1, dev_pndng=1, dev_dpop=0xBEEF next cycle.
REQ-037 SHALL cover: 20 push/pop pairs through RX (wrap twice) -> data order preserved, rx_count returns to 0.
REQ-038 SHALL cover: reset low with tx_count=5 and tx_ovf=1, asynchronously between edges -> pndng, tx_count, tx_ovf read 0 immediately.
